xc20xx_rdbk_ser: RTL and testbench

- Readback serializer, the read side of the serial configuration path.
- Snapshots a parallel frame of captured flip-flop/latch state (e.g. an array of DFFSR Q outputs) when triggered.
- Shifts the frame out on a single serial pin, framed by a fixed preamble and a stop bit.
- Sits between the simulated logic-block array and the readback pin model; the bench checks its stream against the array state.

---
 rtl/xc20xx_rdbk_ser.sv | 177 +++++++++++++++++
 tb/tb_xc20xx_rdbk_ser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/xc20xx_rdbk_ser.sv
// Readback serializer: snapshots a parallel frame on TRIG and shifts it out as preamble, data (MSB first), optional parity, stop.
// Optional even-parity bit is compiled in when XC20XX_RDBK_PARITY_EN is defined.
module xc20xx_rdbk_ser #(
  parameter int                FRAME_W  = 8,
  parameter int                PRE_W    = 4,
  parameter logic [PRE_W-1:0]  PREAMBLE = 4'b0010
) (
  input  logic               K,
  input  logic               R,
  input  logic               TRIG,
  input  logic               CE,
  input  logic [FRAME_W-1:0] DIN,
  output logic               RDATA,
  output logic               BUSY,
  output logic               DONE
);

  localparam int MAX_W = (PRE_W > FRAME_W) ? PRE_W : FRAME_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_STOP = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [FRAME_W-1:0] shreg_r, shreg_s;
  logic [PRE_W-1:0]   pre_r, pre_s;
  logic               rdata_r, rdata_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

`ifdef XC20XX_RDBK_PARITY_EN
  logic               par_r, par_s;

  function automatic logic even_par(input logic [FRAME_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Next-state, counter and shift-register update; nothing advances without CE except acceptance.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    pre_s   = pre_r;
    done_s  = 1'b0;
`ifdef XC20XX_RDBK_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (TRIG) begin
          state_s = ST_HDR;
          cnt_s   = CNT_ZERO;
          shreg_s = DIN;
          pre_s   = PREAMBLE;
`ifdef XC20XX_RDBK_PARITY_EN
          par_s   = even_par(DIN);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (CE) begin
          if (cnt_r == HDR_LAST) begin
            state_s = ST_DATA;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
            pre_s = pre_r << 1'b1;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (CE) begin
          if (cnt_r == DATA_LAST) begin
`ifdef XC20XX_RDBK_PARITY_EN
            state_s = ST_PAR;
`else
            state_s = ST_STOP;
`endif
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
            shreg_s = shreg_r << 1'b1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef XC20XX_RDBK_PARITY_EN
      ST_PAR: begin
        if (CE) begin
          state_s = ST_STOP;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_PAR;
        end
      end
`endif
      ST_STOP: begin
        if (CE) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          done_s  = 1'b1;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output values for the coming cycle, derived from next state so the pins are plain flops.
  always_comb begin
    rdata_s = 1'b1;
    busy_s  = (state_s != ST_IDLE);
    case (state_s)
      ST_IDLE: rdata_s = 1'b1;
      ST_HDR:  rdata_s = pre_s[PRE_W-1];
      ST_DATA: rdata_s = shreg_s[FRAME_W-1];
`ifdef XC20XX_RDBK_PARITY_EN
      ST_PAR:  rdata_s = par_s;
`endif
      ST_STOP: rdata_s = 1'b1;
      default: rdata_s = 1'b1;
    endcase
  end

  // State and output registers; reset abandons any frame in flight without DONE.
  always_ff @(posedge K or negedge R) begin
    if (!R) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      shreg_r <= {FRAME_W{1'b0}};
      pre_r   <= {PRE_W{1'b0}};
      rdata_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef XC20XX_RDBK_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
      pre_r   <= pre_s;
      rdata_r <= rdata_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef XC20XX_RDBK_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign RDATA = rdata_r;
  assign BUSY  = busy_r;
  assign DONE  = done_r;

endmodule

// File: tb/tb_xc20xx_rdbk_ser.sv
// Directed bench for xc20xx_rdbk_ser (FRAME_W=8, PRE_W=4, PREAMBLE=0010); follows XC20XX_RDBK_PARITY_EN if defined.
module tb_xc20xx_rdbk_ser;

`ifdef XC20XX_RDBK_PARITY_EN
  localparam int FLEN = 14;
`else
  localparam int FLEN = 13;
`endif

  logic       K    = 1'b0;
  logic       R    = 1'b0;
  logic       TRIG = 1'b0;
  logic       CE   = 1'b0;
  logic [7:0] DIN  = 8'h00;
  logic       RDATA;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;

  always #5 K = ~K;

  xc20xx_rdbk_ser #(
    .FRAME_W (8),
    .PRE_W   (4),
    .PREAMBLE(4'b0010)
  ) dut (
    .K    (K),
    .R    (R),
    .TRIG (TRIG),
    .CE   (CE),
    .DIN  (DIN),
    .RDATA(RDATA),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  task automatic tick;
    @(posedge K);
    #1;
  endtask

  task automatic test_reset;
    R = 1'b0; TRIG = 1'b0; CE = 1'b0;
    tick; tick;
    checks++; if (RDATA !== 1'b1) begin errors++; $display("FAIL reset_rdata: got %b want 1", RDATA); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    R = 1'b1; CE = 1'b1;
    tick; tick; tick;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_ce_busy: got %b want 0", BUSY); end
    checks++; if (RDATA !== 1'b1) begin errors++; $display("FAIL idle_ce_rdata: got %b want 1", RDATA); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL idle_ce_done: got %b want 0", DONE); end
    CE = 1'b0;
  endtask

  task automatic test_basic;
    logic [13:0] e;
`ifdef XC20XX_RDBK_PARITY_EN
    e = 14'b0010_1010_0101_0_1;
`else
    e = {1'b0, 13'b0010_1010_0101_1};
`endif
    DIN = 8'hA5; TRIG = 1'b1; CE = 1'b1;
    tick;
    TRIG = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      checks++; if (RDATA !== e[FLEN-1-i]) begin errors++; $display("FAIL basic_rdata bit %0d: got %b want %b", i, RDATA, e[FLEN-1-i]); end
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy bit %0d: got %b want 1", i, BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_done_early bit %0d: got %b want 0", i, DONE); end
      tick;
    end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", DONE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", BUSY); end
    checks++; if (RDATA !== 1'b1) begin errors++; $display("FAIL basic_idle_rdata: got %b want 1", RDATA); end
    tick;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", DONE); end
  endtask

  task automatic test_ce_throttle;
    logic [13:0] e;
`ifdef XC20XX_RDBK_PARITY_EN
    e = 14'b0010_1111_1111_0_1;
`else
    e = {1'b0, 13'b0010_1111_1111_1};
`endif
    DIN = 8'hFF; TRIG = 1'b1; CE = 1'b0;
    tick;
    TRIG = 1'b0;
    for (int k = 0; k < 3 * FLEN; k++) begin
      checks++; if (RDATA !== e[FLEN-1-k/3]) begin errors++; $display("FAIL ce_rdata cycle %0d: got %b want %b", k, RDATA, e[FLEN-1-k/3]); end
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL ce_busy cycle %0d: got %b want 1", k, BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL ce_done_early cycle %0d: got %b want 0", k, DONE); end
      CE = ((k + 1) % 3 == 0) ? 1'b1 : 1'b0;
      tick;
    end
    CE = 1'b0;
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL ce_done: got %b want 1", DONE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ce_busy_end: got %b want 0", BUSY); end
    tick;
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL ce_done_pulse: got %b want 0", DONE); end
  endtask

  task automatic test_back_to_back;
    logic [13:0] e1;
    logic [13:0] e2;
`ifdef XC20XX_RDBK_PARITY_EN
    e1 = 14'b0010_0000_0001_1_1;
    e2 = 14'b0010_1000_0000_1_1;
`else
    e1 = {1'b0, 13'b0010_0000_0001_1};
    e2 = {1'b0, 13'b0010_1000_0000_1};
`endif
    DIN = 8'h01; TRIG = 1'b1; CE = 1'b1;
    tick;
    for (int i = 0; i < FLEN; i++) begin
      checks++; if (RDATA !== e1[FLEN-1-i]) begin errors++; $display("FAIL b2b_f1_rdata bit %0d: got %b want %b", i, RDATA, e1[FLEN-1-i]); end
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_f1_busy bit %0d: got %b want 1", i, BUSY); end
      if (i == 1) DIN = 8'h80;
      tick;
    end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", DONE); end
    checks++; if (RDATA !== 1'b1) begin errors++; $display("FAIL b2b_idle_rdata: got %b want 1", RDATA); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", BUSY); end
    tick;
    TRIG = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      checks++; if (RDATA !== e2[FLEN-1-i]) begin errors++; $display("FAIL b2b_f2_rdata bit %0d: got %b want %b", i, RDATA, e2[FLEN-1-i]); end
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_f2_busy bit %0d: got %b want 1", i, BUSY); end
      tick;
    end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", DONE); end
    tick;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_no_third_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL b2b_done2_pulse: got %b want 0", DONE); end
  endtask

  task automatic test_din_stability;
    logic [13:0] e;
`ifdef XC20XX_RDBK_PARITY_EN
    e = 14'b0010_0011_1100_0_1;
`else
    e = {1'b0, 13'b0010_0011_1100_1};
`endif
    DIN = 8'h3C; TRIG = 1'b1; CE = 1'b1;
    tick;
    TRIG = 1'b0; DIN = 8'hC3;
    for (int i = 0; i < FLEN; i++) begin
      checks++; if (RDATA !== e[FLEN-1-i]) begin errors++; $display("FAIL din_rdata bit %0d: got %b want %b", i, RDATA, e[FLEN-1-i]); end
      tick;
    end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL din_done: got %b want 1", DONE); end
    tick;
  endtask

  task automatic test_async_reset;
    DIN = 8'hA5; TRIG = 1'b1; CE = 1'b1;
    tick;
    TRIG = 1'b0;
    repeat (8) tick;
    checks++; if (RDATA !== 1'b0) begin errors++; $display("FAIL arst_pre_rdata: got %b want 0", RDATA); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %b want 1", BUSY); end
    #2;
    R = 1'b0;
    #1;
    checks++; if (RDATA !== 1'b1) begin errors++; $display("FAIL arst_rdata: got %b want 1", RDATA); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", DONE); end
    tick;
    #2;
    R = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL arst_no_done cycle %0d: got %b want 0", i, DONE); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL arst_idle_busy cycle %0d: got %b want 0", i, BUSY); end
    end
    test_basic();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ce_throttle();
    test_back_to_back();
    test_din_stability();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
